// File: rtl/perf_mon_pkg.sv
// Shared types and helpers for the performance event monitor.
package perf_mon_pkg;

  typedef enum logic {COUNT = 1'b0, FROZEN = 1'b1} stateT;

  localparam int MAX_EVENTS = 16;

  // Smallest read-index width that can address every event, the cycle
  // counter and at least one out-of-range index.
  function automatic int idxWidth(input int numEvents);
    return $clog2(numEvents + 2);
  endfunction

endpackage

// File: rtl/perf_mon_if.sv
// Event strobes, control and indexed read port of the performance monitor.
interface perf_mon_if
  import perf_mon_pkg::*;
#(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int IDX_W      = idxWidth(NUM_EVENTS)
) ();

  logic [NUM_EVENTS-1:0] event_in;
  logic                  count_en;
  logic                  clear;
  logic                  halt;
  logic                  rd_req;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_valid;
  logic [CNT_WIDTH-1:0]  rd_data;
  logic                  rd_ovf;
  logic                  rd_err;
  logic                  frozen;

  modport master (
    output event_in, count_en, clear, halt, rd_req, rd_idx,
    input  rd_valid, rd_data, rd_ovf, rd_err, frozen
  );

  modport slave (
    input  event_in, count_en, clear, halt, rd_req, rd_idx,
    output rd_valid, rd_data, rd_ovf, rd_err, frozen
  );

endinterface

// File: rtl/perf_cnt_cell.sv
// One event counter with sticky overflow; saturates or wraps on overflow.
module perf_cnt_cell #(
  parameter int CNT_WIDTH = 16,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  input  logic                 freeze,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 ovf
);

  localparam logic [CNT_WIDTH-1:0] ALL_ONES = '1;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc && !freeze) begin
      if (cnt == ALL_ONES) begin
        ovf <= 1'b1;
        if (!SATURATE) cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_event_monitor.sv
// Event/cycle counter bank with freeze-on-halt and a registered indexed read port.
module perf_event_monitor
  import perf_mon_pkg::*;
#(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int SATURATE   = 1,
  parameter int IDX_W      = 5
) (
  input logic      clk,
  input logic      rst,
  perf_mon_if.slave bus
);

  localparam int CYCLE_IDX = NUM_EVENTS;

  stateT state, nextState;

  logic [CYCLE_IDX:0]                incVec;
  logic [CYCLE_IDX:0]                ovfAll;
  logic [CYCLE_IDX:0][CNT_WIDTH-1:0] cntAll;
  logic                              freeze;

  logic [CNT_WIDTH-1:0] selData, rdData;
  logic                 selOvf, selErr, rdOvf, rdErr, rdValid;

  // Top slot is the cycle counter, which sees an increment every cycle.
  assign incVec = {1'b1, bus.event_in};
  assign freeze = (state == FROZEN) || !bus.count_en;

  for (genvar g = 0; g <= CYCLE_IDX; g++) begin : gCell
    perf_cnt_cell #(
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE != 0)
    ) uCell (
      .clk    (clk),
      .rst    (rst),
      .inc    (incVec[g]),
      .clr    (bus.clear),
      .freeze (freeze),
      .cnt    (cntAll[g]),
      .ovf    (ovfAll[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= COUNT;
    else     state <= nextState;
  end

  // Clear wins over halt; halt is only meaningful while counting.
  always_comb begin
    nextState = state;
    if (bus.clear)                       nextState = COUNT;
    else if (state == COUNT && bus.halt) nextState = FROZEN;
  end

  always_comb begin
    selData = '0;
    selOvf  = 1'b0;
    selErr  = int'(bus.rd_idx) > CYCLE_IDX;
    for (int i = 0; i <= CYCLE_IDX; i++) begin
      if (int'(bus.rd_idx) == i) begin
        selData = cntAll[i];
        selOvf  = ovfAll[i];
      end
    end
  end

  // Sampling pre-edge counter values keeps same-cycle increments invisible.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdValid <= 1'b0;
      rdData  <= '0;
      rdOvf   <= 1'b0;
      rdErr   <= 1'b0;
    end else begin
      rdValid <= bus.rd_req;
      if (bus.rd_req) begin
        rdData <= selData;
        rdOvf  <= selOvf;
        rdErr  <= selErr;
      end
    end
  end

  assign bus.rd_valid = rdValid;
  assign bus.rd_data  = rdData;
  assign bus.rd_ovf   = rdOvf;
  assign bus.rd_err   = rdErr;
  assign bus.frozen   = (state == FROZEN);

endmodule

// File: tb/tb_perf_event_monitor.sv
// Scoreboard bench: one 16-bit saturating monitor plus 4-bit saturating and wrapping variants.
module tb_perf_event_monitor;

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
    logic        err;
  } expT;

  logic       clk, rst;
  logic [3:0] evt;
  logic       cen, clr, hlt;
  logic       reqA, reqB, reqC;
  logic [4:0] idxA, idxB, idxC;
  bit         done;
  int         nCmp, nBad;
  expT        qA[$], qB[$], qC[$];

  perf_mon_if #(.NUM_EVENTS(4), .CNT_WIDTH(16), .IDX_W(5)) ifA ();
  perf_mon_if #(.NUM_EVENTS(4), .CNT_WIDTH(4),  .IDX_W(5)) ifB ();
  perf_mon_if #(.NUM_EVENTS(4), .CNT_WIDTH(4),  .IDX_W(5)) ifC ();

  assign ifA.event_in = evt; assign ifA.count_en = cen; assign ifA.clear = clr; assign ifA.halt = hlt;
  assign ifB.event_in = evt; assign ifB.count_en = cen; assign ifB.clear = clr; assign ifB.halt = hlt;
  assign ifC.event_in = evt; assign ifC.count_en = cen; assign ifC.clear = clr; assign ifC.halt = hlt;
  assign ifA.rd_req = reqA; assign ifA.rd_idx = idxA;
  assign ifB.rd_req = reqB; assign ifB.rd_idx = idxB;
  assign ifC.rd_req = reqC; assign ifC.rd_idx = idxC;

  perf_event_monitor #(.NUM_EVENTS(4), .CNT_WIDTH(16), .SATURATE(1), .IDX_W(5))
    dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
  perf_event_monitor #(.NUM_EVENTS(4), .CNT_WIDTH(4), .SATURATE(1), .IDX_W(5))
    dutB (.clk(clk), .rst(rst), .bus(ifB.slave));
  perf_event_monitor #(.NUM_EVENTS(4), .CNT_WIDTH(4), .SATURATE(0), .IDX_W(5))
    dutC (.clk(clk), .rst(rst), .bus(ifC.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issue a read on unit u (0=A,1=B,2=C) and queue its expected result.
  task automatic rd(input int u, input int idx, input int d, input bit o, input bit e);
    expT x;
    x = '{data: 32'(d), ovf: o, err: e};
    case (u)
      0:       begin reqA = 1'b1; idxA = 5'(idx); qA.push_back(x); end
      1:       begin reqB = 1'b1; idxB = 5'(idx); qB.push_back(x); end
      default: begin reqC = 1'b1; idxC = 5'(idx); qC.push_back(x); end
    endcase
  endtask

  task automatic idle();
    reqA = 1'b0; reqB = 1'b0; reqC = 1'b0;
  endtask

  task automatic mon(input string nm, input int u, input logic v, input logic [31:0] d,
                     input logic o, input logic e);
    expT x;
    bit  have;
    if (v !== 1'b1) return;
    have = 1'b0;
    x    = '0;
    case (u)
      0:       if (qA.size() > 0) begin x = qA.pop_front(); have = 1'b1; end
      1:       if (qB.size() > 0) begin x = qB.pop_front(); have = 1'b1; end
      default: if (qC.size() > 0) begin x = qC.pop_front(); have = 1'b1; end
    endcase
    nCmp++;
    if (!have) begin
      nBad++;
      $display("FAIL %s unexpected rd_valid: data=%0d", nm, d);
    end else if (d !== x.data || o !== x.ovf || e !== x.err) begin
      nBad++;
      $display("FAIL %s read: got data=%0d ovf=%0b err=%0b expected data=%0d ovf=%0b err=%0b",
               nm, d, o, e, x.data, x.ovf, x.err);
    end
  endtask

  initial begin
    nCmp = 0; nBad = 0; done = 1'b0;
    rst = 1'b1; evt = '0; cen = 1'b0; clr = 1'b0; hlt = 1'b0;
    reqA = 1'b0; reqB = 1'b0; reqC = 1'b0; idxA = '0; idxB = '0; idxC = '0;
    fork
      begin
        while (!done) begin
          @(negedge clk);
          mon("A", 0, ifA.rd_valid, 32'(ifA.rd_data), ifA.rd_ovf, ifA.rd_err);
          mon("B", 1, ifB.rd_valid, 32'(ifB.rd_data), ifB.rd_ovf, ifB.rd_err);
          mon("C", 2, ifC.rd_valid, 32'(ifC.rd_data), ifC.rd_ovf, ifC.rd_err);
        end
      end
      begin
        // Reset state
        repeat (2) tick();
        chk("rst_valid",  32'(ifA.rd_valid), 32'd0);
        chk("rst_data",   32'(ifA.rd_data),  32'd0);
        chk("rst_ovf",    32'(ifA.rd_ovf),   32'd0);
        chk("rst_err",    32'(ifA.rd_err),   32'd0);
        chk("rst_frozen", 32'(ifA.frozen),   32'd0);
        rst = 1'b0;

        // Basic counting and back-to-back reads
        cen = 1'b1; evt = 4'b0101;
        repeat (10) tick();
        cen = 1'b0; evt = '0;
        rd(0, 0, 10, 0, 0); tick();
        rd(0, 1, 0, 0, 0);  tick();
        rd(0, 2, 10, 0, 0); tick();
        rd(0, 4, 10, 0, 0); tick();
        idle(); tick();

        // Saturate vs wrap on 4-bit counters
        clr = 1'b1; tick(); clr = 1'b0;
        cen = 1'b1; evt = 4'b0001;
        repeat (20) tick();
        cen = 1'b0; evt = '0;
        rd(0, 0, 20, 0, 0); rd(1, 0, 15, 1, 0); rd(2, 0, 4, 1, 0); tick();
        rd(0, 4, 20, 0, 0); rd(1, 4, 15, 1, 0); rd(2, 4, 4, 1, 0); tick();
        rd(1, 1, 0, 0, 0);  idle(); reqB = 1'b1; tick();
        idle(); tick();

        // Halt freezes; events in the halt cycle still count
        clr = 1'b1; tick(); clr = 1'b0;
        cen = 1'b1;
        for (int c = 1; c <= 5; c++) begin
          evt = (c % 2 == 1) ? 4'b0010 : 4'b0000;
          hlt = (c == 5);
          tick();
        end
        hlt = 1'b0;
        chk("halt_frozen", 32'(ifA.frozen), 32'd1);
        for (int c = 0; c < 10; c++) begin
          evt = (c % 2 == 0) ? 4'b0010 : 4'b0000;
          hlt = (c == 3);
          tick();
        end
        evt = '0; hlt = 1'b0;
        chk("still_frozen", 32'(ifA.frozen), 32'd1);
        rd(0, 1, 3, 0, 0); rd(1, 1, 3, 0, 0); tick();
        idle();
        rd(0, 4, 5, 0, 0); tick();
        rd(0, 0, 0, 0, 0); tick();
        idle(); tick();

        // Clear beats events and halt; next cycle counts from 1
        clr = 1'b1; evt = 4'hF; hlt = 1'b1; cen = 1'b1;
        tick();
        chk("clr_frozen", 32'(ifA.frozen), 32'd0);
        clr = 1'b0; hlt = 1'b0;
        rd(0, 0, 0, 0, 0); tick();
        cen = 1'b0; evt = '0;
        rd(0, 0, 1, 0, 0); rd(1, 0, 1, 0, 0); rd(2, 4, 1, 0, 0); tick();
        idle();
        for (int i = 1; i <= 4; i++) begin
          rd(0, i, 1, 0, 0); tick();
        end
        idle(); tick();

        // Out-of-range index and read/increment ordering
        rd(0, 5, 0, 0, 1);  tick();
        rd(0, 31, 0, 0, 1); tick();
        idle();
        clr = 1'b1; tick(); clr = 1'b0;
        cen = 1'b1; evt = 4'b0100;
        repeat (7) tick();
        rd(0, 2, 7, 0, 0); tick();
        cen = 1'b0; evt = '0;
        rd(0, 2, 8, 0, 0); tick();
        idle(); tick();

        // Reset coinciding with a read request cancels it
        reqA = 1'b1; idxA = 5'd2; rst = 1'b1;
        tick();
        reqA = 1'b0;
        chk("rst_cancel_valid", 32'(ifA.rd_valid), 32'd0);
        tick();
        rst = 1'b0;
        cen = 1'b1; evt = 4'b1000;
        repeat (3) tick();
        cen = 1'b0; evt = '0;
        rd(0, 3, 3, 0, 0); tick();
        rd(0, 2, 0, 0, 0); tick();
        rd(0, 4, 3, 0, 0); tick();
        idle();
        repeat (2) tick();

        chk("qA_drained", 32'(qA.size()), 32'd0);
        chk("qB_drained", 32'(qB.size()), 32'd0);
        chk("qC_drained", 32'(qC.size()), 32'd0);
        done = 1'b1;
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
